// File: rtl/bitorder_pkg.sv
// Shared types and index helpers for the ping-pong symbol-order converter.
package bitorder_pkg;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_RUN  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic full;
    logic end_tag;
    logic rev_tag;
  } slot_tag_t;

  // Bit offset of arrival-order symbol k; the first symbol lands in the most significant slice.
  function automatic int unsigned sym_slice(input int unsigned k,
                                            input int unsigned word_syms,
                                            input int unsigned sym_w);
    return (word_syms - 1 - k) * sym_w;
  endfunction

  function automatic int unsigned out_index(input int unsigned cnt,
                                            input logic        rev,
                                            input int unsigned word_syms);
    return rev ? (word_syms - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/bitorder_slot.sv
// One word buffer with its tag: symbol write port, symbol read port, tag set/clear controls.
module bitorder_slot
  import bitorder_pkg::*;
#(
  parameter int SYM_W     = 2,
  parameter int WORD_SYMS = 4,
  parameter int CNT_W     = $clog2(WORD_SYMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [SYM_W-1:0] wr_sym,
  input  logic             set_rev,
  input  logic             rev_in,
  input  logic             set_full,
  input  logic             end_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] rd_idx,
  output logic [SYM_W-1:0] rd_sym,
  output slot_tag_t        tag
);

  localparam int WORD_W = SYM_W * WORD_SYMS;
  localparam int BASE_W = $clog2(WORD_W);

  logic [WORD_W-1:0] word_q, word_d;
  slot_tag_t         tag_q, tag_d;
  logic [BASE_W-1:0] wr_base, rd_base;

  assign wr_base = BASE_W'(sym_slice(32'(wr_idx), WORD_SYMS, SYM_W));
  assign rd_base = BASE_W'(sym_slice(32'(rd_idx), WORD_SYMS, SYM_W));

  // A fill may set the tag in the same cycle the drain side clears it; the fill wins.
  always_comb begin
    word_d = word_q;
    tag_d  = tag_q;
    if (clr) tag_d.full = 1'b0;
    if (wr_en) word_d[wr_base +: SYM_W] = wr_sym;
    if (set_rev) tag_d.rev_tag = rev_in;
    if (set_full) begin
      tag_d.full    = 1'b1;
      tag_d.end_tag = end_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      tag_q  <= '0;
    end else begin
      word_q <= word_d;
      tag_q  <= tag_d;
    end
  end

  assign rd_sym = word_q[rd_base +: SYM_W];
  assign tag    = tag_q;

endmodule

// File: rtl/bitorder_stream_pp.sv
// Ping-pong symbol-order converter: collects WORD_SYMS symbols per word, re-emits them one per
// cycle in reversed or arrival order, carrying frame-end and flagging truncated words.
//
// state      | meaning
// DRAIN_IDLE | nothing in flight; emits symbol 0 on the cycle the drain slot is seen full
// DRAIN_RUN  | emitting symbol out_cnt of the drain slot
module bitorder_stream_pp
  import bitorder_pkg::*;
#(
  parameter int SYM_W     = 2,
  parameter int WORD_SYMS = 4,
  parameter int CNT_W     = $clog2(WORD_SYMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axiiv,
  input  logic [SYM_W-1:0] axiid,
  input  logic             data_end_in,
  input  logic             reverse,
  output logic             axiov,
  output logic [SYM_W-1:0] axiod,
  output logic             data_end_out,
  output logic             err_trunc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SYMS - 1);

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             fill_sel_q, fill_sel_d;
  logic             drain_sel_q, drain_sel_d;
  drain_state_t     state_q, state_d;
  logic             axiov_q, axiov_d;
  logic [SYM_W-1:0] axiod_q, axiod_d;
  logic             data_end_q, data_end_d;
  logic             err_q, err_d;

  logic             word_done, set_rev;
  logic [1:0]       clr;
  logic [SYM_W-1:0] rd_sym [2];
  slot_tag_t        slot_tag [2];
  slot_tag_t        cur_tag;
  logic [CNT_W-1:0] eff_cnt, rd_idx;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    bitorder_slot #(
      .SYM_W    (SYM_W),
      .WORD_SYMS(WORD_SYMS),
      .CNT_W    (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (axiiv && (fill_sel_q == 1'(s))),
      .wr_idx  (in_cnt_q),
      .wr_sym  (axiid),
      .set_rev (set_rev && (fill_sel_q == 1'(s))),
      .rev_in  (reverse),
      .set_full(word_done && (fill_sel_q == 1'(s))),
      .end_in  (data_end_in),
      .clr     (clr[s]),
      .rd_idx  (rd_idx),
      .rd_sym  (rd_sym[s]),
      .tag     (slot_tag[s])
    );
  end

  always_comb begin
    in_cnt_d   = in_cnt_q;
    fill_sel_d = fill_sel_q;
    err_d      = 1'b0;
    word_done  = 1'b0;
    set_rev    = axiiv && (in_cnt_q == '0);
    if (axiiv) begin
      if (in_cnt_q == LAST) begin
        in_cnt_d   = '0;
        fill_sel_d = ~fill_sel_q;
        word_done  = 1'b1;
      end else if (data_end_in) begin
        in_cnt_d = '0;
        err_d    = 1'b1;
      end else begin
        in_cnt_d = in_cnt_q + 1'b1;
      end
    end else if (in_cnt_q != '0) begin
      in_cnt_d = '0;
      err_d    = 1'b1;
    end
  end

  // IDLE emits symbol 0 directly so the first output lands WORD_SYMS cycles after the first input.
  assign cur_tag = slot_tag[drain_sel_q];
  assign eff_cnt = (state_q == DRAIN_RUN) ? out_cnt_q : '0;
  assign rd_idx  = CNT_W'(out_index(32'(eff_cnt), cur_tag.rev_tag, WORD_SYMS));

  always_comb begin
    state_d     = state_q;
    out_cnt_d   = out_cnt_q;
    drain_sel_d = drain_sel_q;
    axiov_d     = 1'b0;
    axiod_d     = '0;
    data_end_d  = 1'b0;
    clr         = '0;
    if ((state_q == DRAIN_RUN) || cur_tag.full) begin
      axiov_d = 1'b1;
      axiod_d = rd_sym[drain_sel_q];
      if (eff_cnt == LAST) begin
        data_end_d       = cur_tag.end_tag;
        clr[drain_sel_q] = 1'b1;
        drain_sel_d      = ~drain_sel_q;
        out_cnt_d        = '0;
        state_d          = slot_tag[~drain_sel_q].full ? DRAIN_RUN : DRAIN_IDLE;
      end else begin
        out_cnt_d = eff_cnt + 1'b1;
        state_d   = DRAIN_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      state_q     <= DRAIN_IDLE;
      axiov_q     <= 1'b0;
      axiod_q     <= '0;
      data_end_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      state_q     <= state_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      data_end_q  <= data_end_d;
      err_q       <= err_d;
    end
  end

  // Refilling a slot that has not drained yet would corrupt the word in flight.
  assert property (@(posedge clk) disable iff (!rst_n) axiiv |-> !slot_tag[fill_sel_q].full);

  assign axiov        = axiov_q;
  assign axiod        = axiod_q;
  assign data_end_out = data_end_q;
  assign err_trunc    = err_q;

endmodule

// File: tb/tb_bitorder_stream_pp.sv
// Directed and random stimulus for bitorder_stream_pp against a cycle-scheduled word model.
module tb_bitorder_stream_pp;

  localparam int SW = 2;
  localparam int WS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          axiiv, data_end_in, reverse;
  logic [SW-1:0] axiid;
  logic          axiov, data_end_out, err_trunc;
  logic [SW-1:0] axiod;

  logic       b_axiiv, b_de, b_rev;
  logic [3:0] b_axiid;
  logic       b_axiov, b_deo, b_err;
  logic [3:0] b_axiod;

  bitorder_stream_pp #(.SYM_W(SW), .WORD_SYMS(WS)) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .data_end_in(data_end_in),
    .reverse(reverse), .axiov(axiov), .axiod(axiod), .data_end_out(data_end_out),
    .err_trunc(err_trunc)
  );

  bitorder_stream_pp #(.SYM_W(4), .WORD_SYMS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .axiiv(b_axiiv), .axiid(b_axiid), .data_end_in(b_de),
    .reverse(b_rev), .axiov(b_axiov), .axiod(b_axiod), .data_end_out(b_deo),
    .err_trunc(b_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_free = 0;

  // Model: words in progress as a symbol list; finished words scheduled by output cycle.
  logic [SW-1:0] syms[$];
  logic          cur_rev;
  logic [SW-1:0] exp_sym[int];
  logic          exp_end[int];
  logic          exp_err[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [SW-1:0] d, input logic de,
                            input logic rev);
    if (v) begin
      if (syms.size() == 0) cur_rev = rev;
      syms.push_back(d);
      if (syms.size() == WS) begin
        int start;
        start = (cyc + 1 > out_free) ? cyc + 1 : out_free;
        for (int j = 0; j < WS; j++) begin
          exp_sym[start + j] = cur_rev ? syms[WS - 1 - j] : syms[j];
          exp_end[start + j] = de && (j == WS - 1);
        end
        out_free = start + WS;
        syms.delete();
      end else if (de) begin
        exp_err[cyc] = 1'b1;
        syms.delete();
      end
    end else if (syms.size() != 0) begin
      exp_err[cyc] = 1'b1;
      syms.delete();
    end
  endtask

  task automatic step(input logic v, input logic [SW-1:0] d, input logic de, input logic rev);
    axiiv = v; axiid = d; data_end_in = de; reverse = rev;
    @(posedge clk);
    cyc++;
    model_edge(v, d, de, rev);
    #1;
    chk("axiov", 32'(axiov), 32'(exp_sym.exists(cyc)));
    if (exp_sym.exists(cyc)) begin
      chk("axiod", 32'(axiod), 32'(exp_sym[cyc]));
      chk("data_end_out", 32'(data_end_out), 32'(exp_end[cyc]));
    end else begin
      chk("data_end_out_idle", 32'(data_end_out), 32'd0);
    end
    chk("err_trunc", 32'(err_trunc), 32'(exp_err.exists(cyc)));
  endtask

  task automatic send_word(input logic [SW*WS-1:0] w, input logic rev, input logic de);
    for (int k = 0; k < WS; k++)
      step(1'b1, w[(WS - 1 - k) * SW +: SW], de && (k == WS - 1), rev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    axiiv = 1'b0; axiid = '0; data_end_in = 1'b0; reverse = 1'b0;
    b_axiiv = 1'b0; b_axiid = '0; b_de = 1'b0; b_rev = 1'b0;
    #3;
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_axiod", 32'(axiod), 32'd0);
    chk("rst_data_end_out", 32'(data_end_out), 32'd0);
    chk("rst_err_trunc", 32'(err_trunc), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single word, reversed: 0xB4 -> 0,1,3,2
    send_word(8'hB4, 1'b1, 1'b0);
    idle(6);
    // back-to-back
    send_word(8'hB4, 1'b1, 1'b0);
    send_word(8'h1E, 1'b1, 1'b0);
    idle(6);
    // mode latched per word; reverse toggling mid-word is ignored
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b0, 1'b1);
    step(1'b1, 2'd0, 1'b0, 1'b1);
    step(1'b1, 2'd2, 1'b0, 1'b1);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    idle(6);
    // frame of three words, end marker on the last symbol
    send_word(8'h6C, 1'b1, 1'b0);
    send_word(8'h93, 1'b0, 1'b0);
    send_word(8'h2D, 1'b1, 1'b1);
    idle(6);
    // truncation by a gap, then a full word
    step(1'b1, 2'd1, 1'b0, 1'b1);
    step(1'b1, 2'd2, 1'b0, 1'b1);
    idle(3);
    send_word(8'hFF, 1'b1, 1'b0);
    idle(6);
    // truncation by an early frame end
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, SW'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
    idle(6);

    // async reset while output symbol 2 is on the bus
    send_word(8'hB4, 1'b1, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_axiov", 32'(axiov), 32'd0);
    chk("arst_axiod", 32'(axiod), 32'd0);
    chk("arst_data_end_out", 32'(data_end_out), 32'd0);
    syms.delete(); exp_sym.delete(); exp_end.delete(); exp_err.delete();
    out_free = 0;
    axiiv = 1'b0;
    repeat (2) @(posedge clk);
    cyc += 2;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    send_word(8'h1E, 1'b1, 1'b1);
    idle(6);

    // SYM_W=4, WORD_SYMS=2 instance: 0xA5 reversed -> 5,A
    axiiv = 1'b0;
    b_axiiv = 1'b1; b_axiid = 4'hA; b_rev = 1'b1; b_de = 1'b0;
    @(posedge clk); #1;
    b_axiid = 4'h5; b_rev = 1'b0; b_de = 1'b1;
    @(posedge clk); #1;
    b_axiiv = 1'b0; b_de = 1'b0;
    chk("b_axiov_lat", 32'(b_axiov), 32'd0);
    @(posedge clk); #1;
    chk("b_axiov0", 32'(b_axiov), 32'd1);
    chk("b_axiod0", 32'(b_axiod), 32'h5);
    chk("b_end0", 32'(b_deo), 32'd0);
    @(posedge clk); #1;
    chk("b_axiov1", 32'(b_axiov), 32'd1);
    chk("b_axiod1", 32'(b_axiod), 32'hA);
    chk("b_end1", 32'(b_deo), 32'd1);
    @(posedge clk); #1;
    chk("b_axiov2", 32'(b_axiov), 32'd0);
    chk("b_err", 32'(b_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
